fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC, drives the instruction-memory (I-cache) read handshake, and fills the IF/ID register consumed by the decode/control-word stage. Handles three cases: downstream back-pressure (`stall`), and control-flow redirects from EX (taken branch, JAL, JALR), including redirects that arrive while an I-cache request is outstanding.

---
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the RV32I pipeline.
// Owns the PC, runs the I-cache read handshake and fills the IF/ID register.
// A word that returns while decode is stalled parks in a one-entry skid.
// An EX redirect that arrives mid-request turns the outstanding request
// into a stale one, whose response is swallowed.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   imem_address   I-cache read address (stable while a request is open)
//   imem_read      I-cache read request, held until imem_resp
//   imem_rdata     instruction word, valid with imem_resp
//   imem_resp      one-cycle response pulse, retires the open request
//   stall          decode cannot accept; IF/ID holds
//   redirect       EX resolved a taken branch/JAL/JALR
//   redirect_pc    redirect target (low two bits ignored)
//   ifid_valid     IF/ID holds a live instruction
//   ifid_pc        PC of the IF/ID instruction
//   ifid_instr     instruction word in IF/ID
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | request to pc outstanding; responses go to IF/ID or skid
// HOLD    | no request; fetched word waits in skid for decode
// DISCARD | stale request still open; its response is dropped, then
//         | fetching resumes at redir_pc
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] redir_pc;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic [31:0] tgt;
  logic        slot_free;
  logic        consumed;

  assign tgt       = {redirect_pc[31:2], 2'b00};
  assign slot_free = !ifid_valid || !stall;
  assign consumed  = ifid_valid && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (redirect && !imem_resp) begin
          state_next = DISCARD;
        end else if (!redirect && imem_resp && !slot_free) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          state_next = FETCH;
        end
      end
      DISCARD: begin
        if (imem_resp) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // Read is gated by rst so the cache sees an abandoned request during reset.
  always_comb begin
    imem_read    = !rst && (state != HOLD);
    imem_address = pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      redir_pc   <= '0;
      hold_pc    <= '0;
      hold_instr <= '0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= NOP;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            // IF/ID is wrong-path; a coincident response is dropped.
            ifid_valid <= 1'b0;
            if (imem_resp) begin
              pc <= tgt;
            end else begin
              redir_pc <= tgt;
            end
          end else if (imem_resp) begin
            pc <= pc + 32'd4;
            if (slot_free) begin
              ifid_valid <= 1'b1;
              ifid_pc    <= pc;
              ifid_instr <= imem_rdata;
            end else begin
              hold_pc    <= pc;
              hold_instr <= imem_rdata;
            end
          end else if (consumed) begin
            ifid_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            ifid_valid <= 1'b0;
            pc         <= tgt;
          end else if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= hold_pc;
            ifid_instr <= hold_instr;
          end
        end
        DISCARD: begin
          if (redirect || consumed) begin
            ifid_valid <= 1'b0;
          end
          if (redirect) begin
            redir_pc <= tgt;
          end
          // The newest target wins, including one arriving with the response.
          if (imem_resp) begin
            pc <= redirect ? tgt : redir_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage.
// A random-latency cache answers requests with an address-derived word;
// a reference model built from a PC, a stale-request flag, a skid queue and
// the IF/ID triple predicts every output each cycle.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h4000_0060;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          NCYC     = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model
  logic [31:0] m_pc;
  logic [31:0] m_target;
  bit          m_stale;
  logic [63:0] m_skid[$];
  bit          m_iv;
  logic [31:0] m_ipc;
  logic [31:0] m_iins;

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_target = '0;
    m_stale  = 0;
    m_skid.delete();
    m_iv     = 0;
    m_ipc    = '0;
    m_iins   = NOP;
  endtask

  task automatic model_step(input bit r, input bit rsp, input bit stl, input bit rd,
                            input logic [31:0] raw_tgt);
    logic [31:0] t;
    logic [63:0] e;
    bit          consumed;
    t = raw_tgt & 32'hFFFF_FFFC;
    consumed = m_iv && !stl;
    if (r) begin
      model_reset();
    end else if (m_skid.size() != 0) begin
      if (rd) begin
        m_skid.delete();
        m_pc = t;
        m_iv = 0;
      end else if (!stl) begin
        e = m_skid.pop_front();
        m_iv   = 1;
        m_ipc  = e[63:32];
        m_iins = e[31:0];
      end
    end else if (m_stale) begin
      if (rd) m_target = t;
      if (rsp) begin
        m_pc    = m_target;
        m_stale = 0;
      end
      if (rd || consumed) m_iv = 0;
    end else begin
      if (rd) begin
        m_iv = 0;
        if (rsp) begin
          m_pc = t;
        end else begin
          m_target = t;
          m_stale  = 1;
        end
      end else if (rsp) begin
        if (!m_iv || !stl) begin
          m_iv   = 1;
          m_ipc  = m_pc;
          m_iins = word_at(m_pc);
        end else begin
          m_skid.push_back({m_pc, word_at(m_pc)});
        end
        m_pc = m_pc + 32'd4;
      end else if (consumed) begin
        m_iv = 0;
      end
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFC;
      1:       return 32'h4000_0203;
      2:       return 32'h4000_0100;
      3:       return 32'hFFFF_FFF8;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit exp_read;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_resp   = 1'b0;
    imem_rdata  = '0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        exp_read = !rst && (m_skid.size() == 0);
        check_val("imem_read", {31'b0, imem_read}, {31'b0, exp_read});
        if (exp_read) check_val("imem_address", imem_address, m_pc);
        check_val("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_iv});
        check_val("ifid_pc", ifid_pc, m_ipc);
        check_val("ifid_instr", ifid_instr, m_iins);
      end
      rst         = (cyc < 3) || ($urandom_range(0, 299) == 0);
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = (cyc >= 3) && ($urandom_range(0, 9) == 0);
      redirect_pc = pick_target();
      if (cyc == 2000) begin
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
      end
      #1;
      imem_resp  = imem_read && ($urandom_range(0, 1) == 0);
      imem_rdata = imem_resp ? word_at(imem_address) : $urandom;
      model_step(rst, imem_resp, stall, redirect, redirect_pc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
